bf16_to_int: RTL and testbench
==============================

Name: bf16_to_int

Overview:
- Converts a BFloat16 operand to a signed two's-complement integer, rounding toward zero.
- This is the float-to-integer direction; the leading-zero-count based normalizer covers the integer-to-float direction.
- Two-stage pipeline with a valid/ready handshake on both sides; sits in the BF16 datapath next to the int-to-bf16 normalizer.
- Reports IEEE-style invalid, overflow and inexact flags alongside each result.

Parameters:
- INT_W, 16: width of the signed integer result. Legal range 9..32.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- valid_i, input, 1: upstream data valid.
- ready_o, output, 1: block can accept data this cycle.
- data_i, input, 16: BF16 operand. Sign is [15], exponent is [14:7], mantissa is [6:0].
- valid_o, output, 1: result valid.
- ready_i, input, 1: downstream accepts the result this cycle.
- data_o, output, INT_W: signed integer result.
- invalid_o, output, 1: operand was NaN.
- overflow_o, output, 1: result saturated.
- inexact_o, output, 1: nonzero fraction bits were discarded.

Behaviour:
- Reset: the reset is synchronous and active-high. The cycle after rst is sampled high, valid_o=0, data_o=0 and all flags=0. Both stage valids are cleared, so ready_o=1. Reset mid-operation drops in-flight data silently.
- Transfer rule: input transfers when valid_i&&ready_o. Output transfers when valid_o&&ready_i.
- ready_o = ~s1_valid | ~s2_valid | ready_i. This is a combinational function of state and ready_i only; it never depends on valid_i.
- Latency: exactly 2 cycles from input acceptance to valid_o when not stalled. Sustained throughput is 1 per cycle.
- Stage 1 (registered) holds:
  - sign.
  - class: zero, normal, inf, nan.
  - unbiased exponent E = exp-127.
  - the unsigned magnitude.
  - the discarded-bit flag.
- Stage 2 (registered) holds negation, saturation, flags, data_o and valid_o.
- Stall: a stage holds its contents while its downstream is occupied and not advancing. data_o and the flags stay stable while valid_o&&!ready_i. There are no bubbles inserted and no drops.
- Arithmetic, with M = {1,mant} (8 bits):
  - exp==0: result 0. inexact = (mant!=0), since denormals are flushed.
  - exp==255, mant!=0 (NaN): result 0, invalid=1.
  - exp==255, mant==0 (inf): result is +max (2^(INT_W-1)-1) or -min (-2^(INT_W-1)), overflow=1.
  - E<0: result 0, inexact=1.
  - 0<=E<7: mag = M>>(7-E). inexact = OR of the shifted-out bits.
  - 7<=E<=INT_W-2: mag = M<<(E-7), inexact=0.
  - E==INT_W-1, sign=1, mant==0: result -2^(INT_W-1), no overflow.
  - Any other E>=INT_W-1: saturate by sign, overflow=1, inexact=0.
  - Final result = sign ? -mag : mag, computed INT_W wide. -0.0 gives 0.
- Flags are mutually exclusive except inexact, which is only ever set alone.

Test Plan:
- 0x3F80 (1.0), ready_i=1 -> valid_o 2 cycles after acceptance, data_o=0x0001, flags 0. Also 0x8000 (-0) -> 0x0000, flags 0.
- 0xC2F7 (-123.5) -> 0xFF85, inexact=1. Also 0x3F00 (0.5) -> 0x0000, inexact=1. Also 0x0001 (denormal) -> 0x0000, inexact=1.
- Saturation (INT_W=16):
  - 0x4700 (32768) -> 0x7FFF, overflow=1.
  - 0xC700 (-32768) -> 0x8000, overflow=0.
  - 0xFF80 (-inf) -> 0x8000, overflow=1.
  - 0x7FC0 (NaN) -> 0x0000, invalid=1.
- Backpressure: send 1.0, 2.0, 3.0 back-to-back with ready_i=0 for 4 cycles.
  - ready_o goes 0 once both stages are full.
  - data_o stays 0x0001 while stalled.
  - After ready_i=1, outputs are 1, 2, 3 in order, with no loss or duplicates.
- Random ready_i/valid_i stream of 1000 operands checked against a reference model -> every result and flag matches, in order.
- Assert rst for 1 cycle with both stages valid -> next cycle valid_o=0, data_o=0, ready_o=1. The held operands never appear at the output.

Source files
------------

// File: rtl/bf16_to_int.sv
`default_nettype none
// ============================================================================
//  Module   : bf16_to_int
//  Brief    : Two-stage BFloat16 -> signed integer converter (round toward
//             zero, saturating) with valid/ready handshake and IEEE flags.
//  Revision : 1.0 - initial release
// ============================================================================
module bf16_to_int #(
    parameter int INT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [15:0]      data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [INT_W-1:0] data_o,
    output logic             invalid_o,
    output logic             overflow_o,
    output logic             inexact_o
);

    localparam logic [1:0]        c_cls_zero = 2'd0;
    localparam logic [1:0]        c_cls_norm = 2'd1;
    localparam logic [1:0]        c_cls_inf  = 2'd2;
    localparam logic [1:0]        c_cls_nan  = 2'd3;
    localparam logic signed [9:0] c_max_e    = 10'(INT_W - 1);
    localparam logic [INT_W-1:0]  c_int_max  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0]  c_int_min  = {1'b1, {(INT_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_fire;
    logic w_s1_fire;

    assign w_s2_adv  = ~r_s2_valid | ready_i;
    assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
    assign w_in_fire = valid_i & w_s1_adv;
    assign w_s1_fire = r_s1_valid & w_s2_adv;
    assign ready_o   = w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: classify, unbias exponent, align magnitude
    // ------------------------------------------------------------------
    logic              w_in_sign;
    logic [7:0]        w_in_exp;
    logic [6:0]        w_in_mant;
    logic [7:0]        w_in_m;
    logic signed [9:0] w_in_e;
    logic [2:0]        w_shr_amt;
    logic [4:0]        w_shl_amt;
    logic [7:0]        w_keep_mask;
    logic [1:0]        w_in_cls;
    logic [INT_W-1:0]  w_in_mag;
    logic              w_in_lost;

    assign w_in_sign   = data_i[15];
    assign w_in_exp    = data_i[14:7];
    assign w_in_mant   = data_i[6:0];
    assign w_in_m      = {1'b1, w_in_mant};
    assign w_in_e      = $signed({2'b00, w_in_exp}) - 10'sd127;
    assign w_shr_amt   = 3'd7 - w_in_e[2:0];
    assign w_shl_amt   = w_in_e[4:0] - 5'd7;
    assign w_keep_mask = 8'hFF << w_shr_amt;

    always_comb begin
        w_in_cls  = c_cls_norm;
        w_in_mag  = '0;
        w_in_lost = 1'b0;
        if (w_in_exp == 8'h00) begin
            // denormals flush to zero but still report the lost fraction
            w_in_cls  = c_cls_zero;
            w_in_lost = |w_in_mant;
        end else if (w_in_exp == 8'hFF) begin
            w_in_cls = (w_in_mant != 7'd0) ? c_cls_nan : c_cls_inf;
        end else if (w_in_e < 10'sd0) begin
            w_in_lost = 1'b1;
        end else if (w_in_e < 10'sd7) begin
            w_in_mag  = {{(INT_W-8){1'b0}}, w_in_m >> w_shr_amt};
            w_in_lost = |(w_in_m & ~w_keep_mask);
        end else if (w_in_e <= c_max_e) begin
            w_in_mag = {{(INT_W-8){1'b0}}, w_in_m} << w_shl_amt;
        end
    end

    logic              r_s1_sign;
    logic [1:0]        r_s1_cls;
    logic signed [9:0] r_s1_e;
    logic [INT_W-1:0]  r_s1_mag;
    logic              r_s1_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= c_cls_zero;
            r_s1_e     <= '0;
            r_s1_mag   <= '0;
            r_s1_lost  <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= valid_i;
            end
            if (w_in_fire) begin
                r_s1_sign <= w_in_sign;
                r_s1_cls  <= w_in_cls;
                r_s1_e    <= w_in_e;
                r_s1_mag  <= w_in_mag;
                r_s1_lost <= w_in_lost;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate, negate, raise flags
    // ------------------------------------------------------------------
    logic [INT_W-1:0] w_sat;
    logic [INT_W-1:0] w_res;
    logic             w_inv;
    logic             w_ovf;
    logic             w_inx;
    logic             w_is_min;

    assign w_sat    = r_s1_sign ? c_int_min : c_int_max;
    // -2^(INT_W-1) is representable exactly, so it must not be flagged
    assign w_is_min = r_s1_sign && (r_s1_mag == c_int_min);

    always_comb begin
        w_res = '0;
        w_inv = 1'b0;
        w_ovf = 1'b0;
        w_inx = 1'b0;
        case (r_s1_cls)
            c_cls_zero: w_inx = r_s1_lost;
            c_cls_nan:  w_inv = 1'b1;
            c_cls_inf: begin
                w_res = w_sat;
                w_ovf = 1'b1;
            end
            default: begin
                if ((r_s1_e > c_max_e) || ((r_s1_e == c_max_e) && !w_is_min)) begin
                    w_res = w_sat;
                    w_ovf = 1'b1;
                end else begin
                    w_res = r_s1_sign ? -r_s1_mag : r_s1_mag;
                    w_inx = r_s1_lost;
                end
            end
        endcase
    end

    logic [INT_W-1:0] r_s2_data;
    logic             r_s2_inv;
    logic             r_s2_ovf;
    logic             r_s2_inx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_inv   <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_inx   <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_fire) begin
                r_s2_data <= w_res;
                r_s2_inv  <= w_inv;
                r_s2_ovf  <= w_ovf;
                r_s2_inx  <= w_inx;
            end
        end
    end

    assign valid_o    = r_s2_valid;
    assign data_o     = r_s2_data;
    assign invalid_o  = r_s2_inv;
    assign overflow_o = r_s2_ovf;
    assign inexact_o  = r_s2_inx;

endmodule
`default_nettype wire

// File: tb/tb_bf16_to_int.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bf16_to_int
//  Brief    : Self-checking bench for bf16_to_int (INT_W = 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bf16_to_int;

    typedef struct {
        logic [15:0] din;
        logic [15:0] res;
        logic        inv;
        logic        ovf;
        logic        inx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] data_i = 16'h0000;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] data_o;
    logic        invalid_o;
    logic        overflow_o;
    logic        inexact_o;

    logic rnd_mode  = 1'b0;
    logic rnd_rdy   = 1'b1;
    logic ready_dir = 1'b1;
    assign ready_i = rnd_mode ? rnd_rdy : ready_dir;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];

    bf16_to_int #(.INT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .invalid_o  (invalid_o),
        .overflow_o (overflow_o),
        .inexact_o  (inexact_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Independent reference: exact real-valued magnitude, truncated.
    function automatic vec_t model(input logic [15:0] d);
        vec_t r;
        real  m;
        int   e;
        int   t;
        r.din = d; r.res = 16'h0; r.inv = 1'b0; r.ovf = 1'b0; r.inx = 1'b0;
        e = int'(d[14:7]);
        if (e == 0) begin
            r.inx = (d[6:0] != 7'd0);
        end else if (e == 255) begin
            if (d[6:0] != 7'd0) r.inv = 1'b1;
            else begin
                r.ovf = 1'b1;
                r.res = d[15] ? 16'h8000 : 16'h7FFF;
            end
        end else begin
            m = real'(128 + int'(d[6:0]));
            e = e - 134;
            while (e > 0) begin m = m * 2.0; e--; end
            while (e < 0) begin m = m / 2.0; e++; end
            if ((!d[15] && m >= 32768.0) || (d[15] && m > 32768.0)) begin
                r.ovf = 1'b1;
                r.res = d[15] ? 16'h8000 : 16'h7FFF;
            end else begin
                t     = $rtoi(m);
                r.inx = (real'(t) != m);
                r.res = d[15] ? 16'(-t) : 16'(t);
            end
        end
        return r;
    endfunction

    // Output scoreboard: every output transfer must match the oldest accepted operand.
    always @(negedge clk) begin
        vec_t e;
        if (!rst && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got %0h want none", data_o);
            end else begin
                e = sb.pop_front();
                check($sformatf("data[%h]", e.din), 32'(data_o), 32'(e.res));
                check($sformatf("inv[%h]", e.din), 32'(invalid_o), 32'(e.inv));
                check($sformatf("ovf[%h]", e.din), 32'(overflow_o), 32'(e.ovf));
                check($sformatf("inx[%h]", e.din), 32'(inexact_o), 32'(e.inx));
            end
        end
    end

    task automatic send(input vec_t v);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        valid_i = 1'b1;
        data_i  = v.din;
        while (!done) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back(v);
                done = 1'b1;
            end else if (++n > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: got ready_o=0 want 1");
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || valid_o) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    vec_t tbl[16];
    vec_t v;

    initial begin
        tbl[0]  = '{16'h3F80, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{16'hC2F7, 16'hFF85, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{16'h3F00, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{16'h4700, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{16'hC700, 16'h8000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{16'hFF80, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{16'h7FC0, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{16'h7F80, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{16'h46FF, 16'h7F80, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{16'hC6FF, 16'h8080, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{16'hC701, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{16'hBFC0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{16'h0080, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{16'h4380, 16'h0100, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_flags", 32'({invalid_o, overflow_o, inexact_o}), 32'd0);
        tick;

        // Latency: 1.0 presented in cycle 0 appears in cycle 2
        valid_i = 1'b1; data_i = 16'h3F80;
        @(negedge clk);
        check("lat_accept", 32'(ready_o), 32'd1);
        sb.push_back(tbl[0]);
        tick;
        valid_i = 1'b0;
        @(negedge clk);
        check("lat_cyc1_valid", 32'(valid_o), 32'd0);
        tick;
        @(negedge clk);
        check("lat_cyc2_valid", 32'(valid_o), 32'd1);
        check("lat_cyc2_data", 32'(data_o), 32'h0001);
        tick;
        drain("lat_drain");

        // Table vectors, back-to-back
        for (int i = 0; i < 16; i++) send(tbl[i]);
        valid_i = 1'b0;
        drain("tbl_drain");

        // Backpressure: 1.0, 2.0, 3.0 with ready_i low for 4 cycles
        ready_dir = 1'b0;
        send(tbl[0]);
        send(model(16'h4000));
        valid_i = 1'b1; data_i = 16'h4040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_o_low", 32'(ready_o), 32'd0);
            check("bp_valid_o_hold", 32'(valid_o), 32'd1);
            check("bp_data_o_hold", 32'(data_o), 32'h0001);
            tick;
        end
        ready_dir = 1'b1;
        @(negedge clk);
        check("bp_ready_o_back", 32'(ready_o), 32'd1);
        v = model(16'h4040);
        sb.push_back(v);
        tick;
        valid_i = 1'b0;
        drain("bp_drain");

        // Random stream against the reference model
        rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 3) != 0) d[14:7] = 8'($urandom_range(110, 150));
            send(model(d));
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) tick;
            end
        end
        valid_i = 1'b0;
        drain("rnd_drain");
        rnd_mode = 1'b0;

        // Reset with both stages occupied drops the held operands
        ready_dir = 1'b0;
        send(model(16'h4000));
        send(model(16'h4040));
        valid_i = 1'b0;
        @(negedge clk);
        check("rst2_pre_valid", 32'(valid_o), 32'd1);
        check("rst2_pre_ready", 32'(ready_o), 32'd0);
        tick;
        rst = 1'b1;
        sb.delete();
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_valid_o", 32'(valid_o), 32'd0);
        check("rst2_data_o", 32'(data_o), 32'd0);
        check("rst2_ready_o", 32'(ready_o), 32'd1);
        ready_dir = 1'b1;
        repeat (6) tick;
        check("rst2_no_ghost", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
